// File: rtl/sig_meas.sv
// Waveform measurement on an 8-bit ADC stream: window min/max, peak-to-peak,
// and period averaged over NUM_PER hysteresis-qualified rising crossings.
module sig_meas #(
  parameter int WIN_LEN = 1024,
  parameter int NUM_PER = 4,
  parameter int HYST    = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  ad_data,
  output logic        ad_clk,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  vmax,
  output logic [7:0]  vmin,
  output logic [7:0]  vpp,
  output logic [15:0] period,
  output logic        no_cross
);

  localparam int SH = $clog2(NUM_PER);
  localparam int SW = 16 + SH;
  localparam logic [15:0] WIN_LAST = 16'(WIN_LEN - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [4:0]  NCR_LAST = 5'(NUM_PER);

  typedef enum logic [2:0] {S_IDLE, S_MINMAX, S_THRESH, S_PERIOD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      d_q, d_d;
  logic [7:0]      max_q, max_d, min_q, min_d;
  logic [15:0]     win_cnt_q, win_cnt_d;
  logic [7:0]      hi_q, hi_d, lo_q, lo_d;
  logic            armed_q, armed_d;
  logic [4:0]      ncross_q, ncross_d;
  logic [15:0]     t_q, t_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [7:0]      vmax_q, vmax_d, vmin_q, vmin_d, vpp_q, vpp_d;
  logic [15:0]     period_q, period_d;
  logic            no_cross_q, no_cross_d;

  logic [7:0]      mid_w;
  logic [8:0]      hi_w;
  logic [7:0]      spread_w;
  logic            cross_w;
  logic [SW-1:0]   sum_nx;

  always_comb begin
    state_d    = state_q;
    d_d        = ad_data;
    max_d      = max_q;
    min_d      = min_q;
    win_cnt_d  = win_cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    armed_d    = armed_q;
    ncross_d   = ncross_q;
    t_d        = t_q;
    sum_d      = sum_q;
    vmax_d     = vmax_q;
    vmin_d     = vmin_q;
    vpp_d      = vpp_q;
    period_d   = period_q;
    no_cross_d = no_cross_q;
    mid_w      = 8'(({1'b0, max_q} + {1'b0, min_q}) >> 1);
    hi_w       = {1'b0, mid_w} + 9'(HYST);
    spread_w   = max_q - min_q;
    cross_w    = armed_q && (d_q >= hi_q);
    sum_nx     = sum_q + SW'(t_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_MINMAX;
          max_d     = 8'h00;
          min_d     = 8'hFF;
          win_cnt_d = 16'd0;
        end
      end
      S_MINMAX: begin
        if (d_q > max_q) max_d = d_q;
        if (d_q < min_q) min_d = d_q;
        win_cnt_d = win_cnt_q + 16'd1;
        if (win_cnt_q == WIN_LAST) state_d = S_THRESH;
      end
      S_THRESH: begin
        hi_d     = hi_w[8] ? 8'hFF : hi_w[7:0];
        lo_d     = (mid_w < 8'(HYST)) ? 8'h00 : mid_w - 8'(HYST);
        armed_d  = 1'b0;
        ncross_d = 5'd0;
        t_d      = 16'd0;
        sum_d    = '0;
        vmax_d   = max_q;
        vmin_d   = min_q;
        vpp_d    = spread_w;
        // Too little swing to place two distinct thresholds: report flat.
        if ({1'b0, spread_w} <= 9'(2 * HYST)) begin
          state_d    = S_DONE;
          period_d   = 16'd0;
          no_cross_d = 1'b1;
        end else begin
          state_d = S_PERIOD;
        end
      end
      S_PERIOD: begin
        if (cross_w) begin
          armed_d  = 1'b0;
          ncross_d = ncross_q + 5'd1;
          t_d      = 16'd1;
          if (ncross_q != 5'd0) sum_d = sum_nx;
          if (ncross_q == NCR_LAST) begin
            state_d    = S_DONE;
            period_d   = 16'(sum_nx >> SH);
            no_cross_d = 1'b0;
          end
        end else begin
          if (d_q <= lo_q) armed_d = 1'b1;
          t_d = t_q + 16'd1;
          if (t_q == TO_LAST) begin
            state_d    = S_DONE;
            period_d   = 16'd0;
            no_cross_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      d_q        <= 8'h00;
      max_q      <= 8'h00;
      min_q      <= 8'hFF;
      win_cnt_q  <= 16'd0;
      hi_q       <= 8'h00;
      lo_q       <= 8'h00;
      armed_q    <= 1'b0;
      ncross_q   <= 5'd0;
      t_q        <= 16'd0;
      sum_q      <= '0;
      vmax_q     <= 8'h00;
      vmin_q     <= 8'h00;
      vpp_q      <= 8'h00;
      period_q   <= 16'd0;
      no_cross_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      max_q      <= max_d;
      min_q      <= min_d;
      win_cnt_q  <= win_cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      armed_q    <= armed_d;
      ncross_q   <= ncross_d;
      t_q        <= t_d;
      sum_q      <= sum_d;
      vmax_q     <= vmax_d;
      vmin_q     <= vmin_d;
      vpp_q      <= vpp_d;
      period_q   <= period_d;
      no_cross_q <= no_cross_d;
    end
  end

  // Result registers load on entry to DONE so they are valid alongside the pulse.
  assign ad_clk   = clk;
  assign busy     = (state_q != S_IDLE);
  assign valid    = (state_q == S_DONE);
  assign vmax     = vmax_q;
  assign vmin     = vmin_q;
  assign vpp      = vpp_q;
  assign period   = period_q;
  assign no_cross = no_cross_q;

endmodule

// File: tb/tb_sig_meas.sv
// Randomized and directed checks of sig_meas against a sample-position model.
module tb_sig_meas;
  localparam int W  = 1024;
  localparam int NP = 4;
  localparam int H  = 8;
  localparam int TO = 4096;
  localparam int NW = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ad_data = 8'h00;
  logic        ad_clk, busy, valid, no_cross;
  logic [7:0]  vmax, vmin, vpp;
  logic [15:0] period;

  sig_meas #(.WIN_LEN(W), .NUM_PER(NP), .HYST(H), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ad_data(ad_data),
    .ad_clk(ad_clk), .busy(busy), .valid(valid), .vmax(vmax), .vmin(vmin),
    .vpp(vpp), .period(period), .no_cross(no_cross)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] wav [NW];
  int prev_per = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wv(input int i);
    return int'(wav[(i < NW) ? i : NW - 1]);
  endfunction

  // shape 0: square (low half then high half), 1: linear ramp lo_v..hi_v
  task automatic fill_wave(input int shape, input int lo_v, input int hi_v,
                           input int p, input int phase, input int noise);
    for (int n = 0; n < NW; n++) begin
      int ph, v;
      ph = (n + phase) % p;
      if (shape == 0) v = (ph < p / 2) ? lo_v : hi_v;
      else            v = lo_v + (ph * (hi_v - lo_v)) / (p - 1);
      if (noise > 0) v = v + (((n % 2) == 1) ? noise : -noise);
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      wav[n] = 8'(v);
    end
  endtask

  // Window = samples 0..W-1; crossing search starts at sample W+1.
  // Latency counted in clock edges after the edge that accepts start.
  task automatic model(output int e_max, output int e_min, output int e_per,
                       output int e_nc, output int e_lat);
    int mid, hi, lo, n, last, sum;
    bit armed;
    e_max = 0; e_min = 255;
    for (int i = 0; i < W; i++) begin
      if (wv(i) > e_max) e_max = wv(i);
      if (wv(i) < e_min) e_min = wv(i);
    end
    mid = (e_max + e_min) / 2;
    hi  = (mid + H > 255) ? 255 : mid + H;
    lo  = (mid < H) ? 0 : mid - H;
    e_per = 0; e_nc = 1; e_lat = W + 1;
    if (e_max - e_min <= 2 * H) return;
    armed = 0; n = 0; last = 0; sum = 0;
    for (int j = 0; j < 70000; j++) begin
      int s;
      s = wv(W + 1 + j);
      if (armed && s >= hi) begin
        armed = 0;
        if (n > 0) sum += j - last;
        last = j;
        n++;
        if (n == NP + 1) begin
          e_per = sum / NP; e_nc = 0; e_lat = W + 2 + j;
          return;
        end
      end else begin
        if (s <= lo) armed = 1;
        if (j - last == TO - 1) begin
          e_per = 0; e_nc = 1; e_lat = W + 2 + j;
          return;
        end
      end
    end
  endtask

  task automatic run_meas(input string name, input bit extra_start);
    int e_max, e_min, e_per, e_nc, e_lat;
    int c, lat, nvalid, busy_after, busy_mid;
    int g_max, g_min, g_pp, g_per, g_nc;
    model(e_max, e_min, e_per, e_nc, e_lat);
    c = 0; lat = -1; nvalid = 0; busy_after = 1; busy_mid = 0;
    g_max = 0; g_min = 0; g_pp = 0; g_per = 0; g_nc = 0;
    start = 1'b1;
    ad_data = 8'(wv(0));
    @(posedge clk); #1;
    start = 1'b0;
    ad_data = 8'(wv(1));
    while (c < 20000) begin
      @(posedge clk); #1;
      c++;
      if (c == 10) busy_mid = int'(busy);
      if (c == 20) check_eq($sformatf("%s.hold", name), int'(period), prev_per);
      if (valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = c;
          g_max = int'(vmax); g_min = int'(vmin); g_pp = int'(vpp);
          g_per = int'(period); g_nc = int'(no_cross);
        end
      end
      if (lat >= 0 && c == lat + 1) begin
        busy_after = int'(busy);
        break;
      end
      start = (extra_start && c == 100);
      ad_data = 8'(wv(c + 1));
    end
    check_eq($sformatf("%s.valid_seen", name), (lat >= 0) ? 1 : 0, 1);
    check_eq($sformatf("%s.latency", name), lat, e_lat);
    check_eq($sformatf("%s.nvalid", name), nvalid, 1);
    check_eq($sformatf("%s.busy_mid", name), busy_mid, 1);
    check_eq($sformatf("%s.busy_after", name), busy_after, 0);
    check_eq($sformatf("%s.vmax", name), g_max, e_max);
    check_eq($sformatf("%s.vmin", name), g_min, e_min);
    check_eq($sformatf("%s.vpp", name), g_pp, e_max - e_min);
    check_eq($sformatf("%s.period", name), g_per, e_per);
    check_eq($sformatf("%s.no_cross", name), g_nc, e_nc);
    prev_per = e_per;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".vmax"}, int'(vmax), 0);
    check_eq({tag, ".vmin"}, int'(vmin), 0);
    check_eq({tag, ".vpp"}, int'(vpp), 0);
    check_eq({tag, ".period"}, int'(period), 0);
    check_eq({tag, ".no_cross"}, int'(no_cross), 0);
    check_eq({tag, ".busy"}, int'(busy), 0);
    check_eq({tag, ".valid"}, int'(valid), 0);
  endtask

  initial begin
    int nv;
    #12;
    check_zero("reset");
    #5;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("ad_clk", int'(ad_clk), int'(clk));

    fill_wave(0, 0, 255, 50, 0, 0);
    run_meas("sq50", 1'b1);
    fill_wave(1, 0, 127, 100, 0, 0);
    run_meas("saw100", 1'b0);
    check_eq("saw100.period_abs", int'(period), 100);
    fill_wave(0, 128, 128, 10, 0, 0);
    run_meas("flat", 1'b0);
    fill_wave(0, 0, 255, 5000, 2000, 0);
    run_meas("timeout", 1'b0);
    fill_wave(0, 50, 200, 40, 0, 6);
    run_meas("noisy40", 1'b0);
    check_eq("noisy40.period_abs", int'(period), 40);

    // Abort a measurement part-way with a one-cycle reset pulse.
    fill_wave(0, 0, 255, 50, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    nv = 0;
    repeat (1500) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    check_eq("rst_mid.no_valid", nv, 0);
    prev_per = 0;

    for (int r = 0; r < 4; r++) begin
      int lo_v, hi_v, p;
      lo_v = int'($urandom_range(0, 100));
      hi_v = int'($urandom_range(150, 255));
      p    = int'($urandom_range(20, 150));
      fill_wave(int'($urandom_range(0, 1)), lo_v, hi_v, p,
                int'($urandom_range(0, 149)), int'($urandom_range(0, 5)));
      run_meas($sformatf("rand%0d", r), r[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
